// File: rtl/viewport_map.sv
// viewport_map: clips a projected vertex, maps X/Y to screen pixels with a shift-add multiplier, saturates depth.
// Define VIEWPORT_ROUND_EN to round pixel coordinates to nearest instead of truncating.
module viewport_map #(
    parameter int N = 32,
    parameter int Q = 15,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    input  logic                        start,
    input  logic [N-1:0]                X,
    input  logic [N-1:0]                Y,
    input  logic [N-1:0]                Z,
    output logic [$clog2(SCREEN_W)-1:0] PIX_X,
    output logic [$clog2(SCREEN_H)-1:0] PIX_Y,
    output logic [15:0]                 DEPTH,
    output logic                        CLIPPED,
    output logic                        BUSY,
    output logic                        DONE
);
    localparam int PW = $clog2(SCREEN_W);
    localparam int PH = $clog2(SCREEN_H);
    localparam int UW = Q + 2;
    localparam int AW = UW + (PW > PH ? PW : PH);
    localparam int CW = $clog2(UW);
    localparam logic signed [N-1:0] ONE = N'(2 ** Q);
    localparam logic [AW-1:0] MW = AW'(SCREEN_W - 1);
    localparam logic [AW-1:0] MH = AW'(SCREEN_H - 1);
`ifdef VIEWPORT_ROUND_EN
    localparam logic [AW-1:0] RND = AW'(2 ** Q);
`else
    localparam logic [AW-1:0] RND = '0;
`endif

    typedef enum logic [2:0] {IDLE, CLIP, MULX, MULY, OUT} state_t;
    state_t state;

    logic [N-1:0]  x_r, y_r, z_r;
    logic [UW-1:0] uy_r, mul;
    logic [AW-1:0] acc, acc_next, res;
    logic [CW-1:0] cnt;
    logic          clip, last;

    always_comb begin
        acc_next = acc + (mul[0] ? ((state == MULX ? MW : MH) << cnt) : '0);
        res = (acc_next + RND) >> (Q + 1);
        last = cnt == CW'(UW - 1);
        clip = ($signed(x_r) > ONE) || ($signed(x_r) < -ONE) ||
               ($signed(y_r) > ONE) || ($signed(y_r) < -ONE) ||
               z_r[N-1] || (z_r == '0);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            x_r     <= '0;
            y_r     <= '0;
            z_r     <= '0;
            uy_r    <= '0;
            mul     <= '0;
            acc     <= '0;
            cnt     <= '0;
            PIX_X   <= '0;
            PIX_Y   <= '0;
            DEPTH   <= '0;
            CLIPPED <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (start) begin
                        x_r   <= X;
                        y_r   <= Y;
                        z_r   <= Z;
                        BUSY  <= 1'b1;
                        state <= CLIP;
                    end
                end
                CLIP: begin
                    CLIPPED <= clip;
                    if (clip) begin
                        PIX_X <= '0;
                        PIX_Y <= '0;
                        DEPTH <= '0;
                        DONE  <= 1'b1;
                        state <= OUT;
                    end else begin
                        // ux and uy are non-negative and fit Q+2 bits once the clip test passes
                        DEPTH <= |z_r[N-1:16] ? 16'hFFFF : z_r[15:0];
                        mul   <= UW'(x_r + ONE);
                        uy_r  <= UW'(ONE - y_r);
                        acc   <= '0;
                        cnt   <= '0;
                        state <= MULX;
                    end
                end
                MULX: begin
                    acc <= acc_next;
                    mul <= mul >> 1;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        PIX_X <= PW'(res);
                        mul   <= uy_r;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= MULY;
                    end
                end
                MULY: begin
                    acc <= acc_next;
                    mul <= mul >> 1;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        PIX_Y <= PH'(res);
                        DONE  <= 1'b1;
                        state <= OUT;
                    end
                end
                OUT: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_viewport_map.sv
// tb_viewport_map: directed vectors with a scoreboard queue checked by an independent DONE monitor.
module tb_viewport_map;
`ifdef VIEWPORT_ROUND_EN
    localparam bit R = 1'b1;
`else
    localparam bit R = 1'b0;
`endif

    logic        CLK = 1'b0, RESET_N = 1'b0, start = 1'b0;
    logic [31:0] X = '0, Y = '0, Z = '0;
    logic [9:0]  PIX_X;
    logic [8:0]  PIX_Y;
    logic [15:0] DEPTH;
    logic        CLIPPED, BUSY, DONE;

    viewport_map dut (
        .CLK(CLK), .RESET_N(RESET_N), .start(start), .X(X), .Y(Y), .Z(Z),
        .PIX_X(PIX_X), .PIX_Y(PIX_Y), .DEPTH(DEPTH), .CLIPPED(CLIPPED),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int px;
        int py;
        int d;
        int c;
        int lat;
        int acc;
    } exp_t;

    exp_t sb[$];
    exp_t last_e = '{0, 0, 0, 0, 0, 0};
    int checks = 0, passes = 0, last_acc = -1;
    bit prev_done = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Latency is counted in edges from the accept edge to the edge that raises DONE.
    always @(negedge CLK) begin
        if (prev_done) begin
            chk("done_width", int'(DONE), 0);
            chk("busy_idle", int'(BUSY), 0);
        end
        if (DONE && RESET_N) begin
            if (sb.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("pix_x", int'(PIX_X), e.px);
                chk("pix_y", int'(PIX_Y), e.py);
                chk("depth", int'(DEPTH), e.d);
                chk("clipped", int'(CLIPPED), e.c);
                chk("latency", cyc - e.acc, e.lat);
                chk("busy_done", int'(BUSY), 1);
                last_e = e;
            end
        end
        prev_done = DONE;
    end

    task automatic send(input logic [31:0] x, y, z, input int px, py, d, input bit c, input bit hold);
        int n = 0;
        @(negedge CLK);
        while (BUSY && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (BUSY) chk("idle_timeout", 1, 0);
        X = x;
        Y = y;
        Z = z;
        start = 1'b1;
        if (hold && last_acc >= 0) chk("spacing", cyc + 1 - last_acc, 37);
        last_acc = hold ? cyc + 1 : -1;
        sb.push_back('{px, py, d, int'(c), c ? 1 : 35, cyc + 1});
        @(posedge CLK);
        #1;
        X = $urandom;
        Y = $urandom;
        Z = $urandom;
        if (!hold) start = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pix_x"}, int'(PIX_X), 0);
        chk({tag, "_pix_y"}, int'(PIX_Y), 0);
        chk({tag, "_depth"}, int'(DEPTH), 0);
        chk({tag, "_clipped"}, int'(CLIPPED), 0);
        chk({tag, "_busy"}, int'(BUSY), 0);
        chk({tag, "_done"}, int'(DONE), 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge CLK);
        check_zero("reset");
        RESET_N = 1'b1;
        send(32'h8000, 32'h8000, 32'h8000, 639, 0, 32'h8000, 0, 0);
        send(32'hFFFF8000, 32'hFFFF8000, 32'h8000, 0, 479, 32'h8000, 0, 0);
        send(32'h4000, 32'hFFFFC000, 32'h100, 479, 359, 32'h100, 0, 0);
        send(32'h1, 32'h0, 32'h1, R ? 320 : 319, R ? 240 : 239, 1, 0, 0);
        send(32'h0, 32'h0, 32'h12345, R ? 320 : 319, R ? 240 : 239, 16'hFFFF, 0, 0);
        send(32'h0, 32'h0, 32'h10000, R ? 320 : 319, R ? 240 : 239, 16'hFFFF, 0, 0);
        send(32'h8001, 32'h0, 32'h8000, 0, 0, 0, 1, 0);
        send(32'hFFFF7FFF, 32'h0, 32'h8000, 0, 0, 0, 1, 0);
        send(32'h0, 32'h8001, 32'h8000, 0, 0, 0, 1, 0);
        send(32'h0, 32'hFFFF7FFF, 32'h8000, 0, 0, 0, 1, 0);
        send(32'h0, 32'h0, 32'h0, 0, 0, 0, 1, 0);
        send(32'h0, 32'h0, 32'hFFFFFFFF, 0, 0, 0, 1, 0);
        send(32'h8000, 32'h8000, 32'h8000, 639, 0, 32'h8000, 0, 1);
        send(32'hFFFF8000, 32'hFFFF8000, 32'h7FFF, 0, 479, 32'h7FFF, 0, 1);
        send(32'h4000, 32'hFFFFC000, 32'h100, 479, 359, 32'h100, 0, 1);
        send(32'h8000, 32'hFFFF8000, 32'h2, 639, 479, 2, 0, 0);
        send(32'h4000, 32'hFFFFC000, 32'h55, 479, 359, 32'h55, 0, 0);
        repeat (10) @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        check_zero("abort");
        void'(sb.pop_back());
        @(negedge CLK);
        RESET_N = 1'b1;
        send(32'h0, 32'h0, 32'h8000, R ? 320 : 319, R ? 240 : 239, 32'h8000, 0, 0);
        n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() > 0) chk("drain", sb.size(), 0);
        repeat (5) @(negedge CLK);
        chk("hold_pix_x", int'(PIX_X), last_e.px);
        chk("hold_pix_y", int'(PIX_Y), last_e.py);
        chk("hold_depth", int'(DEPTH), last_e.d);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
